// File: rtl/regfile_dump_reader_pkg.sv
// Shared constants and state type for the register-file dump reader.
package regfile_dump_reader_pkg;

  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = $clog2(NUM_REGS);
  localparam int DATA_W     = 32;

  typedef enum logic [1:0] {
    DUMP_IDLE,
    DUMP_FETCH,
    DUMP_SEND
  } dump_state_t;

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Valid/ready stream of (index, data) words leaving the dump reader.
interface regfile_dump_reader_if;
  import regfile_dump_reader_pkg::*;

  logic                  out_valid;
  logic                  out_ready;
  logic [REG_ADDR_W-1:0] out_index;
  logic [DATA_W-1:0]     out_data;
  logic                  out_last;

  modport master (
    output out_valid,
    output out_index,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_index,
    input  out_data,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/regfile_dump_reader.sv
// Walks every register through one read port and streams (index, data)
// words to a debug sink, one word per cycle when the sink never stalls.
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic [REG_ADDR_W-1:0] rd_reg,
  input  logic [DATA_W-1:0]     rd_data,
  output logic                  busy,
  output logic                  done,
  regfile_dump_reader_if.master out_if
);

  dump_state_t           state_q, state_d;
  logic [REG_ADDR_W:0]   ptr_q, ptr_d;
  logic [REG_ADDR_W-1:0] out_index_q, out_index_d;
  logic [DATA_W-1:0]     out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  done_q, done_d;
  logic                  out_last;
  logic                  fire;

  // The extra ptr bit lets it reach NUM_REGS after the last capture; the
  // read address is parked at 0 whenever the engine is idle.
  assign rd_reg   = (state_q == DUMP_IDLE) ? '0 : ptr_q[REG_ADDR_W-1:0];
  assign out_last = out_valid_q && (out_index_q == REG_ADDR_W'(NUM_REGS - 1));
  assign fire     = out_valid_q && out_if.out_ready;

  assign out_if.out_valid = out_valid_q;
  assign out_if.out_index = out_index_q;
  assign out_if.out_data  = out_data_q;
  assign out_if.out_last  = out_last;
  assign busy             = (state_q != DUMP_IDLE);
  assign done             = done_q;

  // State register, pointer and output word, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= DUMP_IDLE;
      ptr_q       <= '0;
      out_index_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      out_index_q <= out_index_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  // Next state: abort cancels anything in flight; a capture loads the word
  // at ptr and advances ptr, either from FETCH or on a non-final handshake.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    out_index_d = out_index_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;

    if (abort) begin
      state_d     = DUMP_IDLE;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        DUMP_IDLE: begin
          if (start) begin
            ptr_d   = '0;
            state_d = DUMP_FETCH;
          end
        end
        DUMP_FETCH: begin
          out_data_d  = rd_data;
          out_index_d = ptr_q[REG_ADDR_W-1:0];
          out_valid_d = 1'b1;
          ptr_d       = ptr_q + {{REG_ADDR_W{1'b0}}, 1'b1};
          state_d     = DUMP_SEND;
        end
        DUMP_SEND: begin
          if (fire) begin
            if (out_last) begin
              out_valid_d = 1'b0;
              done_d      = 1'b1;
              state_d     = DUMP_IDLE;
            end else begin
              out_data_d  = rd_data;
              out_index_d = ptr_q[REG_ADDR_W-1:0];
              ptr_d       = ptr_q + {{REG_ADDR_W{1'b0}}, 1'b1};
            end
          end
        end
        default: begin
          state_d     = DUMP_IDLE;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Testbench: dump reader paired with a behavioural register file preloaded
// so that register i holds i; the sink applies randomized backpressure.
module tb_regfile_dump_reader;
  import regfile_dump_reader_pkg::*;

  logic                  clk;
  logic                  rst_n;
  logic                  start;
  logic                  abort;
  logic [REG_ADDR_W-1:0] rd_reg;
  logic [DATA_W-1:0]     rd_data;
  logic                  busy;
  logic                  done;

  regfile_dump_reader_if dif ();

  regfile_dump_reader dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .rd_reg  (rd_reg),
    .rd_data (rd_data),
    .busy    (busy),
    .done    (done),
    .out_if  (dif)
  );

  // Register file with combinational read; register 0 always reads as 0.
  logic [DATA_W-1:0] rf [NUM_REGS];
  assign rd_data = (rd_reg == '0) ? '0 : rf[rd_reg];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference: the word expected for each register index in a dump.
  logic [DATA_W-1:0]     exp_data [NUM_REGS];

  logic [REG_ADDR_W-1:0] got_idx  [$];
  logic [DATA_W-1:0]     got_data [$];
  logic                  got_last [$];
  int                    done_pulses;
  int                    done_iter;
  int                    first_valid_iter;
  int                    stall_bad;
  bit                    timed_out;
  bit                    hook_fired;

  task automatic preload();
    for (int i = 0; i < NUM_REGS; i++) begin
      rf[i]       = DATA_W'(i);
      exp_data[i] = DATA_W'(i);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Sink: records accepted words, watches stall stability and optionally
  // fires one event (1 write, 2 start, 3 abort, 4 reset) at hook_idx.
  task automatic collect(input int ready_mode, input int hook, input int hook_idx,
                         input int max_cycles);
    bit                    prev_stall;
    bit                    hook_now;
    logic [REG_ADDR_W-1:0] prev_idx;
    logic [DATA_W-1:0]     prev_data;
    got_idx.delete();
    got_data.delete();
    got_last.delete();
    done_pulses      = 0;
    done_iter        = -1;
    first_valid_iter = -1;
    stall_bad        = 0;
    timed_out        = 1'b0;
    hook_fired       = 1'b0;
    prev_stall       = 1'b0;
    prev_idx         = '0;
    prev_data        = '0;
    for (int c = 0; c < max_cycles; c++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      rst_n = 1'b1;
      if (hook_fired && (hook == 3 || hook == 4)) return;
      if (done === 1'b1) begin
        done_pulses++;
        done_iter     = c;
        dif.out_ready = 1'b0;
        return;
      end
      if (prev_stall && (dif.out_valid !== 1'b1 || dif.out_index !== prev_idx ||
                         dif.out_data !== prev_data))
        stall_bad++;
      if (dif.out_valid === 1'b1 && first_valid_iter < 0) first_valid_iter = c;
      hook_now = 1'b0;
      if (!hook_fired && hook != 0 && dif.out_valid === 1'b1 &&
          int'(dif.out_index) == hook_idx) begin
        hook_fired = 1'b1;
        hook_now   = 1'b1;
        case (hook)
          1: begin
            rf[5] = 32'hDEADBEEF;
            rf[1] = 32'h1111_1111;
          end
          2: start = 1'b1;
          3: abort = 1'b1;
          default: rst_n = 1'b0;
        endcase
      end
      case (ready_mode)
        0:       dif.out_ready = 1'b1;
        1:       dif.out_ready = ($urandom_range(0, 3) != 0);
        default: dif.out_ready = ((c % 3) != 2);
      endcase
      if (hook_now && (hook == 3 || hook == 4)) begin
        prev_stall = 1'b0;
        continue;
      end
      if (dif.out_valid === 1'b1 && dif.out_ready) begin
        got_idx.push_back(dif.out_index);
        got_data.push_back(dif.out_data);
        got_last.push_back(dif.out_last);
      end
      prev_stall = (dif.out_valid === 1'b1) && !dif.out_ready;
      prev_idx   = dif.out_index;
      prev_data  = dif.out_data;
    end
    timed_out = 1'b1;
  endtask

  task automatic test_reset();
    logic [45:0] obs;
    rst_n         = 1'b0;
    start         = 1'b0;
    abort         = 1'b0;
    dif.out_ready = 1'b0;
    preload();
    repeat (3) @(negedge clk);
    obs = {dif.out_valid, dif.out_last, done, busy, dif.out_index, dif.out_data, rd_reg};
    total++;
    if (obs !== '0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got=%h exp=0", obs);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_dump();
    $display("[TB] full dump, sink always ready");
    preload();
    pulse_start();
    collect(0, 0, 0, 200);
    total++;
    if (timed_out !== 1'b0) begin
      bad++;
      $display("[TB] FAIL full_timeout: got=%0d exp=0", timed_out);
    end
    total++;
    if (got_idx.size() != NUM_REGS) begin
      bad++;
      $display("[TB] FAIL full_count: got=%0d exp=%0d", got_idx.size(), NUM_REGS);
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        total++;
        if (got_idx[i] !== REG_ADDR_W'(i) || got_data[i] !== exp_data[i] ||
            got_last[i] !== (i == NUM_REGS - 1)) begin
          bad++;
          $display("[TB] FAIL full_word%0d: got idx=%0d data=%h last=%b exp idx=%0d data=%h last=%b",
                   i, got_idx[i], got_data[i], got_last[i], i, exp_data[i], (i == NUM_REGS - 1));
        end
      end
    end
    total++;
    if (first_valid_iter != 0) begin
      bad++;
      $display("[TB] FAIL first_valid_latency: got=%0d exp=2 edges", first_valid_iter + 2);
    end
    total++;
    if (done_iter + 2 != NUM_REGS + 2) begin
      bad++;
      $display("[TB] FAIL done_latency: got=%0d exp=%0d edges", done_iter + 2, NUM_REGS + 2);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL done_pulse_width: got done=%b busy=%b exp done=0 busy=0", done, busy);
    end
  endtask

  task automatic test_backpressure();
    for (int mode = 1; mode <= 2; mode++) begin
      $display("[TB] backpressure mode %0d", mode);
      preload();
      pulse_start();
      collect(mode, 0, 0, 400);
      total++;
      if (timed_out !== 1'b0 || got_idx.size() != NUM_REGS) begin
        bad++;
        $display("[TB] FAIL bp_count: got=%0d timeout=%0d exp=%0d timeout=0",
                 got_idx.size(), timed_out, NUM_REGS);
      end else begin
        for (int i = 0; i < NUM_REGS; i++) begin
          total++;
          if (got_idx[i] !== REG_ADDR_W'(i) || got_data[i] !== exp_data[i]) begin
            bad++;
            $display("[TB] FAIL bp_word%0d: got idx=%0d data=%h exp idx=%0d data=%h",
                     i, got_idx[i], got_data[i], i, exp_data[i]);
          end
        end
      end
      total++;
      if (stall_bad != 0) begin
        bad++;
        $display("[TB] FAIL bp_stall_stable: got=%0d changes exp=0", stall_bad);
      end
    end
  endtask

  task automatic test_coherence();
    $display("[TB] write r5 and r1 while streaming");
    preload();
    exp_data[5] = 32'hDEADBEEF;
    pulse_start();
    collect(1, 1, 2, 400);
    total++;
    if (got_idx.size() != NUM_REGS) begin
      bad++;
      $display("[TB] FAIL coh_count: got=%0d exp=%0d", got_idx.size(), NUM_REGS);
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        total++;
        if (got_idx[i] !== REG_ADDR_W'(i) || got_data[i] !== exp_data[i]) begin
          bad++;
          $display("[TB] FAIL coh_word%0d: got idx=%0d data=%h exp idx=%0d data=%h",
                   i, got_idx[i], got_data[i], i, exp_data[i]);
        end
      end
    end
  endtask

  task automatic test_start_while_busy();
    int extra;
    $display("[TB] start pulsed again mid-dump");
    preload();
    pulse_start();
    collect(1, 2, 10, 400);
    total++;
    if (got_idx.size() != NUM_REGS || done_pulses != 1) begin
      bad++;
      $display("[TB] FAIL restart_ignored_count: got=%0d done=%0d exp=%0d done=1",
               got_idx.size(), done_pulses, NUM_REGS);
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        total++;
        if (got_idx[i] !== REG_ADDR_W'(i) || got_data[i] !== exp_data[i]) begin
          bad++;
          $display("[TB] FAIL restart_word%0d: got idx=%0d data=%h exp idx=%0d data=%h",
                   i, got_idx[i], got_data[i], i, exp_data[i]);
        end
      end
    end
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    total++;
    if (extra != 0) begin
      bad++;
      $display("[TB] FAIL restart_single_done: got=%0d extra busy/done cycles exp=0", extra);
    end
  endtask

  task automatic test_abort();
    int extra;
    $display("[TB] abort mid-dump then restart");
    preload();
    pulse_start();
    collect(1, 3, 10, 400);
    total++;
    if (dif.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rd_reg !== '0) begin
      bad++;
      $display("[TB] FAIL abort_state: got valid=%b busy=%b done=%b rd_reg=%0d exp all 0",
               dif.out_valid, busy, done, rd_reg);
    end
    total++;
    if (got_idx.size() != 10) begin
      bad++;
      $display("[TB] FAIL abort_words_before: got=%0d exp=10", got_idx.size());
    end
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (done === 1'b1 || dif.out_valid === 1'b1) extra++;
    end
    total++;
    if (extra != 0) begin
      bad++;
      $display("[TB] FAIL abort_no_done: got=%0d exp=0", extra);
    end
    pulse_start();
    collect(0, 0, 0, 200);
    total++;
    if (got_idx.size() != NUM_REGS || done_pulses != 1) begin
      bad++;
      $display("[TB] FAIL abort_restart_count: got=%0d done=%0d exp=%0d done=1",
               got_idx.size(), done_pulses, NUM_REGS);
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        total++;
        if (got_idx[i] !== REG_ADDR_W'(i) || got_data[i] !== exp_data[i]) begin
          bad++;
          $display("[TB] FAIL abort_restart_word%0d: got idx=%0d data=%h exp idx=%0d data=%h",
                   i, got_idx[i], got_data[i], i, exp_data[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_dump();
    logic [45:0] obs;
    $display("[TB] reset mid-dump, then start+abort together");
    preload();
    pulse_start();
    collect(1, 4, 20, 400);
    obs = {dif.out_valid, dif.out_last, done, busy, dif.out_index, dif.out_data, rd_reg};
    total++;
    if (obs !== '0) begin
      bad++;
      $display("[TB] FAIL midreset_outputs: got=%h exp=0", obs);
    end
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    total++;
    if (busy !== 1'b0 || dif.out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL start_abort_idle: got busy=%b valid=%b exp busy=0 valid=0",
               busy, dif.out_valid);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL start_abort_stays_idle: got busy=%b done=%b exp 0 0", busy, done);
    end
  endtask

  initial begin
    test_reset();
    test_full_dump();
    test_backpressure();
    test_coherence();
    test_start_while_busy();
    test_abort();
    test_reset_mid_dump();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
